parc_dpath_dmemresp_queue: RTL

//  - Parametrised N-entry data-memory response queue for the PARCv2 M stage.
//  - Replaces the single dmemresp register and its separate en/val controls with a val/rdy FIFO.
//  - Applies load subword adjustment (lw/lb/lbu/lh/lhu) at enqueue; entries are stored already adjusted.
//  - Holds responses that arrive while M/W are stalled, so dmem never back-pressures the pipeline.

---
 rtl/parc_dpath_dmemresp_queue_if.sv | 23 ++
 rtl/parc_dpath_dmemresp_queue.sv | 101 ++++++++++
 2 files changed

// File: rtl/parc_dpath_dmemresp_queue_if.sv
// Handshake bundle between dmem response, the M-stage response queue and the writeback mux.
// The queue itself takes the slave modport; the producer/consumer pair takes master.
interface parc_dpath_dmemresp_queue_if #(
  parameter int DATA_W = 32
);
  logic              enq_val;
  logic              enq_rdy;
  logic [DATA_W-1:0] enq_data;
  logic [2:0]        enq_sel;
  logic              deq_val;
  logic              deq_rdy;
  logic [DATA_W-1:0] deq_data;

  modport master (
    output enq_val, enq_data, enq_sel, deq_rdy,
    input  enq_rdy, deq_val, deq_data
  );

  modport slave (
    input  enq_val, enq_data, enq_sel, deq_rdy,
    output enq_rdy, deq_val, deq_data
  );
endinterface

// File: rtl/parc_dpath_dmemresp_queue.sv
// N-entry val/rdy queue for dmem load responses; data is subword-adjusted on the way in.
// Optional zero-latency empty-queue bypass: define PARC_DMEMRESP_QUEUE_BYPASS_EN.
module parc_dpath_dmemresp_queue #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  parc_dpath_dmemresp_queue_if.slave     resp,
  output logic [PTR_W:0]                 count,
  output logic                           full,
  output logic                           empty
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] enq_adj;
  logic              bypass;
  logic              enq_fire;
  logic              deq_fire;
  logic              bypass_fire;
  logic              write;
  logic              read;

  // Out-of-range selects must give zero rather than X.
  function automatic logic [DATA_W-1:0] adjust(input logic [DATA_W-1:0] d,
                                               input logic [2:0]        sel);
    logic [DATA_W-1:0] r;
    case (sel)
      3'd0:    r = d;
      3'd1:    r = {{(DATA_W-8){d[7]}}, d[7:0]};
      3'd2:    r = {{(DATA_W-8){1'b0}}, d[7:0]};
      3'd3:    r = {{(DATA_W-16){d[15]}}, d[15:0]};
      3'd4:    r = {{(DATA_W-16){1'b0}}, d[15:0]};
      default: r = '0;
    endcase
    return r;
  endfunction

  assign enq_adj = adjust(resp.enq_data, resp.enq_sel);
  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);

`ifdef PARC_DMEMRESP_QUEUE_BYPASS_EN
  assign bypass = empty & resp.enq_val & ~flush & ~reset;
`else
  assign bypass = 1'b0;
`endif

  // A flushing cycle must look idle on both sides.
  assign resp.enq_rdy = ~full & ~flush;
  assign resp.deq_val = ~flush & (~empty | bypass);

  always_comb begin
    resp.deq_data = '0;
    if (bypass)
      resp.deq_data = enq_adj;
    else if (!empty)
      resp.deq_data = mem[rd_ptr];
  end

  assign enq_fire    = resp.enq_val & resp.enq_rdy;
  assign deq_fire    = resp.deq_val & resp.deq_rdy;
  // A bypassed response consumed in the same cycle never touches storage.
  assign bypass_fire = bypass & deq_fire;
  assign write       = enq_fire & ~bypass_fire;
  assign read        = deq_fire & ~bypass_fire;

  always_ff @(posedge clk) begin
    if (write)
      mem[wr_ptr] <= enq_adj;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (write)
        wr_ptr <= wr_ptr + 1'b1;
      if (read)
        rd_ptr <= rd_ptr + 1'b1;
      case ({write, read})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
